// File: rtl/shared_adder_pkg.sv
// shared_adder_pkg: shared constants and helpers for the shared adder and its arbiter.
package shared_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // A one-channel build still needs a one-bit tag.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_adder_rr_arbiter.sv
// rr_arbiter: round-robin arbiter whose search starts just after the last granted requester.
module rr_arbiter
    import shared_adder_pkg::*;
#(
    parameter int N = 4,
    localparam int W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         enable,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr;
    logic         found;

    // The first pass covers indices above the pointer and the second pass wraps to 0..ptr.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i > int'(ptr)) begin
                found     = 1'b1;
                grant_idx = W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && i <= int'(ptr)) begin
                found     = 1'b1;
                grant_idx = W'(i);
            end
        end
        for (int i = 0; i < N; i++) grant[i] = found && enable && grant_idx == W'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr <= W'(N - 1);
        else if (advance) ptr <= grant_idx;
    end

endmodule

// File: rtl/shared_adder_rr.sv
// shared_adder_rr: one adder time-shared across NCH channels with round-robin grant and a registered result.
// When SHARED_ADDER_SUB_EN is defined, a per-channel op bit selects subtraction and is returned as rsp_sub.
module shared_adder_rr
    import shared_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH = 4,
    localparam int CH_W = clog2_min1(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     req_valid,
    output logic [NCH-1:0]     req_ready,
    input  logic [NCH*WIDTH-1:0] req_a,
    input  logic [NCH*WIDTH-1:0] req_b,
`ifdef SHARED_ADDER_SUB_EN
    input  logic [NCH-1:0]     req_sub,
    output logic               rsp_sub,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [CH_W-1:0]    rsp_ch,
    output logic [WIDTH:0]     rsp_sum
);

    logic             slot_free;
    logic             xfer;
    logic [CH_W-1:0]  grant_idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic [WIDTH:0]   sum;

    // Ready is held low during reset so that no requester sees a handshake that is then discarded.
    assign slot_free = rst_n && (!rsp_valid || rsp_ready);
    assign xfer      = |(req_valid & req_ready);

    rr_arbiter #(.N(NCH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .enable    (slot_free),
        .advance   (xfer),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    always_comb begin
        a  = '0;
        b  = '0;
        op = OP_ADD;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                a = req_a[i*WIDTH +: WIDTH];
                b = req_b[i*WIDTH +: WIDTH];
`ifdef SHARED_ADDER_SUB_EN
                op = req_sub[i];
`endif
            end
        end
        sum = (op == OP_SUB) ? {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1) : {1'b0, a} + {1'b0, b};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_ch    <= '0;
            rsp_sum   <= '0;
`ifdef SHARED_ADDER_SUB_EN
            rsp_sub   <= OP_ADD;
`endif
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_ch    <= grant_idx;
            rsp_sum   <= sum;
`ifdef SHARED_ADDER_SUB_EN
            rsp_sub   <= op;
`endif
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shared_adder_rr.sv
// tb_shared_adder_rr: directed-vector bench for shared_adder_rr (WIDTH=8, NCH=4).
module tb_shared_adder_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
`ifdef SHARED_ADDER_SUB_EN
    logic [3:0]  req_sub;
    logic        rsp_sub;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_ch;
    logic [8:0]  rsp_sum;

    int tests = 0;
    int failed = 0;

    shared_adder_rr #(.WIDTH(8), .NCH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef SHARED_ADDER_SUB_EN
        .req_sub   (req_sub),
        .rsp_sub   (rsp_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ch    (rsp_ch),
        .rsp_sum   (rsp_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] ch, input logic [8:0] sum);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".ch"}, 32'(rsp_ch), 32'(ch));
        check({tag, ".sum"}, 32'(rsp_sum), 32'(sum));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a     = {8'h40, 8'h30, 8'h20, 8'h10};
        req_b     = {8'h04, 8'h03, 8'h02, 8'h01};
`ifdef SHARED_ADDER_SUB_EN
        req_sub   = 4'h0;
`endif
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_valid", 32'(rsp_valid), 32'd0);
            check("rst_ready", 32'(req_ready), 32'd0);
        end
        check("rst_ch", 32'(rsp_ch), 32'd0);
        check("rst_sum", 32'(rsp_sum), 32'd0);
        rst_n = 1'b1;
        #1;
        check("first_grant", 32'(req_ready), 32'b0001);
        // Sum on channel i is 0x11*(i+1).
        for (int k = 0; k < 6; k++) begin
            tick();
            check_rsp($sformatf("rr%0d", k), 2'(k % 4), 9'(8'h11 * (k % 4 + 1)));
        end
        rsp_ready = 1'b0;
        #1;
        check("stall_ready0", 32'(req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_rsp($sformatf("stall%0d", k), 2'd1, 9'h022);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("release_grant", 32'(req_ready), 32'b0100);
        tick();
        check_rsp("release", 2'd2, 9'h033);
        req_valid = 4'b0000;
        tick();
        check("pop_valid", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = 4'b1010;
        #1;
        check("alt_grant3", 32'(req_ready), 32'b1000);
        tick();
        check_rsp("alt3a", 2'd3, 9'h044);
        req_valid = 4'b0000;
        tick();
        tick();
        check("idle_valid", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1010;
        #1;
        check("alt_grant1", 32'(req_ready), 32'b0010);
        tick();
        check_rsp("alt1", 2'd1, 9'h022);
        tick();
        check_rsp("alt3b", 2'd3, 9'h044);
        req_valid = 4'b0100;
        req_a[16 +: 8] = 8'hFF;
        req_b[16 +: 8] = 8'h01;
        tick();
        check_rsp("carry", 2'd2, 9'h100);
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_sum", 32'(rsp_sum), 32'd0);
        check("midrst_ch", 32'(rsp_ch), 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("midrst_grant", 32'(req_ready), 32'b0010);
        tick();
        check_rsp("midrst_first", 2'd1, 9'h022);
`ifdef SHARED_ADDER_SUB_EN
        req_valid = 4'b0001;
        req_a[7:0] = 8'h05;
        req_b[7:0] = 8'h07;
        req_sub = 4'b0001;
        tick();
        check_rsp("sub", 2'd0, 9'h0FE);
        check("sub_flag", 32'(rsp_sub), 32'd1);
        req_sub = 4'b0000;
        tick();
        check_rsp("add", 2'd0, 9'h00C);
        check("add_flag", 32'(rsp_sub), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
